// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: one bit per clock to the right,
// left operations wrapped as reverse -> right shift -> reverse.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_left,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // state   | meaning
    // IDLE    | waiting for a request, in_ready high
    // REV_IN  | bit-reverse operand before a left operation
    // SHIFT   | one right shift/rotate per clock until the count expires
    // REV_OUT | bit-reverse result after a left operation
    // DONE    | result presented, waiting for out_ready
    typedef enum logic [2:0] {
        IDLE,
        REV_IN,
        SHIFT,
        REV_OUT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] cnt;
    logic             lft;
    logic             rot;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // The data register doubles as the output register.
    assign out_data = d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            d         <= '0;
            cnt       <= '0;
            lft       <= 1'b0;
            rot       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d        <= in_data;
                        cnt      <= in_amt;
                        lft      <= in_left;
                        rot      <= in_rot;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_left) begin
                            state <= REV_IN;
                        end else if (in_amt != '0) begin
                            state <= SHIFT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                REV_IN: begin
                    d <= bitrev(d);
                    if (cnt != '0) begin
                        state <= SHIFT;
                    end else begin
                        state <= REV_OUT;
                    end
                end
                SHIFT: begin
                    d   <= {(rot ? d[0] : 1'b0), d[WIDTH-1:1]};
                    cnt <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        if (lft) begin
                            state <= REV_OUT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                REV_OUT: begin
                    d         <= bitrev(d);
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
